// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - two-requester round-robin arbiter in front of a single-port memory
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   reqN, weN, addrN, wdataN requester N command (held until gntN)
//   gntN                     one-cycle pulse: requester N command accepted (issue cycle)
//   rvalidN, rdataN          one-cycle read-completion pulse and held read data for requester N
//   busy                     FSM is not idle
//   mem_wr, mem_re           memory write / read enables (issue cycle only)
//   mem_addr, mem_din        memory address / write data (from command registers)
//   mem_dout                 registered memory read data
module mem_arb #(
  parameter int DATA_WIDTH = 2,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  busy,
  output logic                  mem_wr,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  last_q, last_d;        // id granted most recently
  logic                  cmd_we_q, cmd_we_d;
  logic                  cmd_id_q, cmd_id_d;
  logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_WIDTH-1:0] cmd_wdata_q, cmd_wdata_d;
  logic                  gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic                  mem_wr_q, mem_wr_d, mem_re_q, mem_re_d;
  logic                  rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                  win_id;
  logic                  win_we;

  // On a tie the requester that did not win last time goes next.
  assign win_id = (req0 && req1) ? ~last_q : req1;
  assign win_we = win_id ? we1 : we0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      cmd_we_q    <= 1'b0;
      cmd_id_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cmd_we_q    <= cmd_we_d;
      cmd_id_q    <= cmd_id_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      mem_wr_q    <= mem_wr_d;
      mem_re_q    <= mem_re_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cmd_we_d    = cmd_we_q;
    cmd_id_d    = cmd_id_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    mem_wr_d    = 1'b0;
    mem_re_d    = 1'b0;
    rvalid0_d   = 1'b0;
    rvalid1_d   = 1'b0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // Grant and memory strobes are computed here so that they come
          // straight out of flops during ISSUE.
          state_d     = ISSUE;
          last_d      = win_id;
          cmd_id_d    = win_id;
          cmd_we_d    = win_we;
          cmd_addr_d  = win_id ? addr1 : addr0;
          cmd_wdata_d = win_id ? wdata1 : wdata0;
          gnt0_d      = ~win_id;
          gnt1_d      = win_id;
          mem_wr_d    = win_we;
          mem_re_d    = ~win_we;
        end
      end
      ISSUE: begin
        state_d = cmd_we_q ? IDLE : RESP;
      end
      RESP: begin
        state_d = IDLE;
        if (cmd_id_q) begin
          rdata1_d  = mem_dout;
          rvalid1_d = 1'b1;
        end else begin
          rdata0_d  = mem_dout;
          rvalid0_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign rvalid0  = rvalid0_q;
  assign rvalid1  = rvalid1_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;
  assign busy     = (state_q != IDLE);
  assign mem_wr   = mem_wr_q;
  assign mem_re   = mem_re_q;
  assign mem_addr = cmd_addr_q;
  assign mem_din  = cmd_wdata_q;

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter DATA_WIDTH, default 2, width of memory data word.
REQ-002 Parameter ADDR_WIDTH, default 2, width of memory address.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 req0, req1  input  1 each  requester i requests an access; held until gnt_i seen.
REQ-006 we0, we1  input  1 each  requester i access type: 1 write, 0 read; stable while req_i high.
REQ-007 addr0, addr1  input  ADDR_WIDTH each  requester i address; stable while req_i high.
REQ-008 wdata0, wdata1  input  DATA_WIDTH each  requester i write data; stable while req_i high.
REQ-009 gnt0, gnt1  output  1 each  one-cycle pulse: request of requester i accepted.
REQ-010 rvalid0, rvalid1  output  1 each  one-cycle pulse: rdata_i holds read result.
REQ-011 rdata0, rdata1  output  DATA_WIDTH each  read data for requester i.
REQ-012 busy  output  1  high whenever the FSM is not in IDLE.
REQ-013 mem_wr  output  1  memory write enable.
REQ-014 mem_re  output  1  memory read enable.
REQ-015 mem_addr  output  ADDR_WIDTH  memory address.
REQ-016 mem_din  output  DATA_WIDTH  memory write data.
REQ-017 mem_dout  input  DATA_WIDTH  memory registered read data, valid the cycle after the edge sampling mem_re=1 with mem_wr=0.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, RESP; one transaction in flight at most.
REQ-019 IDLE: if req0 or req1 high at an edge, winner selected, its we/addr/wdata and id latched into command registers, next state ISSUE; else stay IDLE.
REQ-020 Arbitration: only one requester high -> it wins; both high -> requester not granted most recently wins (round-robin).
REQ-021 Round-robin pointer SHALL update only on a grant, to the id just granted.
REQ-022 ISSUE: gnt of latched id high for exactly this cycle; mem_addr/mem_din from command registers; mem_wr = cmd_we; mem_re = !cmd_we.
REQ-023 ISSUE -> IDLE if write; ISSUE -> RESP if read.
REQ-024 Outside ISSUE mem_wr and mem_re SHALL be 0; mem_wr and mem_re never both 1.
REQ-025 mem_addr, mem_din, mem_wr, mem_re, gnt_i SHALL be driven from registers (no combinational path from req/addr/wdata inputs).
REQ-026 RESP: mem_dout valid; at end of RESP, rdata of owner loaded from mem_dout, rvalid of owner high for the following single cycle, next state IDLE.
REQ-027 rdata_i SHALL hold its last value until the next read completion for requester i.
REQ-028 Timing: req sampled at edge E0; gnt during cycle E0-E1; memory op at E1; read data captured at E2; rvalid during E2-E3; write throughput 1 per 2 cycles, read 1 per 3 cycles.
REQ-029 Requester deasserting req before gnt SHALL not be granted if req low at the IDLE sampling edge; req changes outside IDLE are ignored.
REQ-030 A read and write from different requesters to the same address are serialized in grant order; a read granted after a write returns the written value.
REQ-031 rvalid for requester i and a new IDLE sample MAY coincide in the same cycle; no other output overlap.

Reset
REQ-032 rst_n low SHALL immediately force state IDLE, pointer to "last granted = 1" (requester 0 wins first tie), command registers 0.
REQ-033 During and after reset: gnt0/1=0, rvalid0/1=0, rdata0/1=0, busy=0, mem_wr=0, mem_re=0, mem_addr=0, mem_din=0.
REQ-034 Reset mid-transaction SHALL abort it: no gnt or rvalid issued afterwards for it; memory contents not reset.

Verification
REQ-035 Write then read, requester 0: we0=1 addr0=2 wdata0=3, then we0=0 addr0=2 -> mem_wr pulse with mem_addr=2 mem_din=3; rvalid0 pulse 3 cycles after read req sampled, rdata0=3.
REQ-036 Simultaneous req0 and req1 out of reset, both reads -> gnt0 first, then gnt1; repeat with both held -> grants alternate 0,1,0,1.
REQ-037 req1 write addr=1 data=2 and req0 read addr=1 same cycle, pointer favoring 1 -> write granted first, rdata0=2.
REQ-038 Only req1 held continuously with reads -> gnt1 every 3 cycles, gnt0 never asserted, mem_wr always 0.
REQ-039 rst_n low during RESP of read for requester 0 -> rvalid0 stays 0, busy=0 immediately, all mem_* outputs 0.
REQ-040 Assertion throughout all tests: at most one gnt, at most one rvalid, never mem_wr and mem_re together, mem_* idle outside ISSUE.
